// File: rtl/sample_packetizer_pkg.sv
// Shared types and width helpers for the sample packetizer.
package sample_packetizer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR_SEQ,
    HDR_LEN,
    PAYLOAD
  } tx_state_t;

  localparam int unsigned HDR_WORDS = 2;
  localparam int unsigned SEQ_W     = 16;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every DIV enabled cycles.
module sample_tick_gen
  import sample_packetizer_pkg::*;
#(
  parameter int unsigned DIV = 556
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic enable,
  output logic tick
);

  localparam int unsigned     CNT_W   = cnt_w(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter freezes while disabled so the sample phase is preserved.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sample_packetizer.sv
// Ping-pong sample capture with a framed valid/ready packet sender.
module sample_packetizer
  import sample_packetizer_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SAMPLES = 18,
  parameter int unsigned DIV     = 556
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              overflow,
  input  logic              clear_overflow,
  output logic [SEQ_W-1:0]  seq_num
);

  localparam int unsigned      IDX_W     = cnt_w(SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SAMPLES - 1);
  localparam int unsigned      PKT_WORDS = SAMPLES + HDR_WORDS;

  if (DATA_W < 16 || SAMPLES < 2 || DIV < 2 || $clog2(PKT_WORDS + 1) > DATA_W) begin : g_bad_param
    $error("sample_packetizer: illegal parameter set");
  end

  logic [DATA_W-1:0] bank_q [2][SAMPLES];

  tx_state_t         state_q, state_d;
  logic              fill_q, fill_d;
  logic              tx_bank_q, tx_bank_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]  nxt_ptr;
  logic [1:0]        full_q, full_d;
  logic              overflow_q, overflow_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic              tick;
  logic              hs;
  logic              eop_hs;
  logic              ovf_set;

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .enable (enable),
    .tick   (tick)
  );

  assign hs      = out_valid_q & out_ready;
  assign eop_hs  = hs && (state_q == PAYLOAD) && (rd_ptr_q == LAST_IDX);
  assign nxt_ptr = rd_ptr_q + IDX_W'(1);

  // Sample storage carries no reset; the full flags say what is valid.
  always_ff @(posedge CLK) begin
    if (tick) bank_q[fill_q][idx_q] <= sample_in;
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    tx_bank_d   = tx_bank_q;
    idx_d       = idx_q;
    rd_ptr_d    = rd_ptr_q;
    full_d      = full_q;
    overflow_d  = overflow_q;
    seq_d       = seq_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    ovf_set     = 1'b0;

    // Capture side; a bank being freed by this cycle's eop counts as empty.
    if (tick) begin
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        if (full_q[~fill_q] && !(eop_hs && (tx_bank_q != fill_q))) begin
          ovf_set = 1'b1;
        end else begin
          full_d[fill_q] = 1'b1;
          fill_d         = ~fill_q;
        end
      end
    end

    if (clear_overflow) overflow_d = 1'b0;
    if (ovf_set)        overflow_d = 1'b1;

    // Sender side; out_* hold their value until the current word is accepted.
    unique case (state_q)
      IDLE: begin
        if (|full_q) begin
          state_d     = HDR_SEQ;
          tx_bank_d   = full_q[1];
          out_valid_d = 1'b1;
          out_sop_d   = 1'b1;
          out_eop_d   = 1'b0;
          out_data_d  = DATA_W'(seq_q);
        end
      end
      HDR_SEQ: begin
        if (hs) begin
          state_d    = HDR_LEN;
          out_sop_d  = 1'b0;
          out_data_d = DATA_W'(SAMPLES);
        end
      end
      HDR_LEN: begin
        if (hs) begin
          state_d    = PAYLOAD;
          rd_ptr_d   = '0;
          out_data_d = bank_q[tx_bank_q][0];
          out_eop_d  = 1'b0;
        end
      end
      PAYLOAD: begin
        if (hs) begin
          if (rd_ptr_q == LAST_IDX) begin
            full_d[tx_bank_q] = 1'b0;
            seq_d             = seq_q + SEQ_W'(1);
            out_eop_d         = 1'b0;
            if (full_d[~tx_bank_q]) begin
              state_d    = HDR_SEQ;
              tx_bank_d  = ~tx_bank_q;
              out_sop_d  = 1'b1;
              out_data_d = DATA_W'(seq_d);
            end else begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              out_sop_d   = 1'b0;
              out_data_d  = '0;
            end
          end else begin
            rd_ptr_d   = nxt_ptr;
            out_data_d = bank_q[tx_bank_q][nxt_ptr];
            out_eop_d  = (nxt_ptr == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      fill_q      <= 1'b0;
      tx_bank_q   <= 1'b0;
      idx_q       <= '0;
      rd_ptr_q    <= '0;
      full_q      <= '0;
      overflow_q  <= 1'b0;
      seq_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      tx_bank_q   <= tx_bank_d;
      idx_q       <= idx_d;
      rd_ptr_q    <= rd_ptr_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      seq_q       <= seq_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign overflow  = overflow_q;
  assign seq_num   = seq_q;

endmodule

// File: tb/tb_sample_packetizer.sv
// Directed bench for sample_packetizer with DIV=4, SAMPLES=4.
module tb_sample_packetizer;
  import sample_packetizer_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned NS = 4;
  localparam int unsigned DV = 4;
  localparam int unsigned PW = NS + HDR_WORDS;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          enable;
  logic [DW-1:0] sample_in;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;
  logic          overflow;
  logic          clear_overflow;
  logic [15:0]   seq_num;

  sample_packetizer #(.DATA_W(DW), .SAMPLES(NS), .DIV(DV)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .enable         (enable),
    .sample_in      (sample_in),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .seq_num        (seq_num)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc;
  int m_cnt;
  int m_ticks;
  int first_valid;
  int gap_ticks;
  logic [DW-1:0] q_data[$];
  logic          q_sop[$];
  logic          q_eop[$];
  bit            stall;
  logic [DW+2:0] stall_snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: log an accepted word, advance, then refresh the tick model.
  task automatic step();
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_sop.push_back(out_sop);
      q_eop.push_back(out_eop);
    end
    stall      = out_valid && !out_ready;
    stall_snap = {out_valid, out_sop, out_eop, out_data};
    @(posedge CLK);
    #1;
    if (enable) begin
      if (m_cnt == DV - 1) begin
        m_cnt = 0;
        m_ticks++;
      end else begin
        m_cnt++;
      end
    end
    sample_in = DW'(m_ticks + 1);
    cyc++;
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (stall) chk("stall_hold", 32'({out_valid, out_sop, out_eop, out_data}), 32'(stall_snap));
  endtask

  task automatic reset_assert();
    RST_N          = 1'b0;
    enable         = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    sample_in      = '0;
    stall          = 1'b0;
  endtask

  task automatic reset_release();
    @(posedge CLK);
    #1;
    RST_N       = 1'b1;
    enable      = 1'b1;
    m_cnt       = 0;
    m_ticks     = 0;
    sample_in   = DW'(1);
    cyc         = 0;
    first_valid = -1;
    q_data.delete();
    q_sop.delete();
    q_eop.delete();
  endtask

  task automatic reset_dut();
    reset_assert();
    repeat (2) @(posedge CLK);
    reset_release();
  endtask

  task automatic run_until(input int n, input int budget, input bit toggle);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      if (toggle) out_ready = ~out_ready;
      step();
      k++;
    end
    chk("word_count", 32'(q_data.size()), 32'(n));
  endtask

  task automatic check_pkt(input int base, input logic [15:0] seq, input int first);
    logic [DW-1:0] w;
    logic [DW+1:0] exp;
    logic [DW+1:0] obs;
    for (int i = 0; i < PW; i++) begin
      if (i == 0)      w = DW'(seq);
      else if (i == 1) w = DW'(NS);
      else             w = DW'(first + i - 2);
      exp = {(i == 0), (i == PW - 1), w};
      if (base + i < q_data.size()) obs = {q_sop[base+i], q_eop[base+i], q_data[base+i]};
      else                          obs = 'x;
      chk($sformatf("pkt%0d_word%0d", base / PW, i), 32'(obs), 32'(exp));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    32'(out_valid), 32'd0);
    chk({tag, "_data"},     32'(out_data),  32'd0);
    chk({tag, "_sop"},      32'(out_sop),   32'd0);
    chk({tag, "_eop"},      32'(out_eop),   32'd0);
    chk({tag, "_overflow"}, 32'(overflow),  32'd0);
    chk({tag, "_seq"},      32'(seq_num),   32'd0);
  endtask

  initial begin
    reset_assert();
    #1;
    chk_all_zero("reset");

    // Basic packet and its latency from the fourth tick.
    reset_dut();
    out_ready = 1'b1;
    run_until(PW, 40, 1'b0);
    chk("first_valid_cycle", 32'(first_valid), 32'(NS * DV - 1 + 2));
    check_pkt(0, 16'h0000, 1);
    chk("seq_after_pkt", 32'(seq_num), 32'd1);
    chk("idle_after_pkt", 32'(out_valid), 32'd0);

    // Alternating backpressure over two packets.
    reset_dut();
    run_until(2 * PW, 80, 1'b1);
    check_pkt(0, 16'h0000, 1);
    check_pkt(PW, 16'h0001, NS + 1);
    chk("toggle_no_overflow", 32'(overflow), 32'd0);

    // Long stall: second and third banks dropped, fourth sent after release.
    reset_dut();
    out_ready = 1'b0;
    repeat (2 * NS * DV - 1) step();
    chk("ovf_before_drop", 32'(overflow), 32'd0);
    step();
    chk("ovf_after_drop", 32'(overflow), 32'd1);
    repeat (18) step();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    run_until(2 * PW, 60, 1'b0);
    check_pkt(0, 16'h0000, 1);
    check_pkt(PW, 16'h0001, 3 * NS + 1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Enable gap after two samples.
    reset_dut();
    out_ready = 1'b1;
    repeat (2 * DV) step();
    enable    = 1'b0;
    gap_ticks = 0;
    repeat (50) begin
      step();
      if (dut.tick) gap_ticks++;
    end
    chk("gap_ticks", 32'(gap_ticks), 32'd0);
    chk("gap_no_valid", 32'(out_valid), 32'd0);
    enable = 1'b1;
    run_until(PW, 60, 1'b0);
    check_pkt(0, 16'h0000, 1);

    // Asynchronous reset during the handshake of packet word 3.
    reset_dut();
    out_ready = 1'b1;
    run_until(3, 40, 1'b0);
    chk("pre_reset_word3", 32'(out_data), 32'd2);
    #2;
    reset_assert();
    #1;
    chk_all_zero("midpkt_reset");
    reset_release();
    out_ready = 1'b1;
    run_until(PW, 40, 1'b0);
    check_pkt(0, 16'h0000, 1);

    // Sequence number wrap.
    reset_dut();
    out_ready = 1'b1;
    repeat (5) step();
    force dut.seq_q = 16'hFFFF;
    repeat (5) step();
    release dut.seq_q;
    step();
    chk("seq_forced", 32'(seq_num), 32'hFFFF);
    run_until(2 * PW, 80, 1'b0);
    check_pkt(0, 16'hFFFF, 1);
    check_pkt(PW, 16'h0000, NS + 1);
    chk("seq_after_wrap", 32'(seq_num), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
